// File: rtl/vector_issue_sequencer.sv
// vector_issue_sequencer: walks one decoded vector op over ITR elements.
// Optional perf counters are enabled by defining VSEQ_PERF_CNT_EN.
module vector_issue_sequencer #(
    parameter int ADDR_W  = 10,
    parameter int MAC_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              is_vle32_vv,
    input  logic              is_vse32_vv,
    input  logic              is_vmacc_vv,
    input  logic              is_vmv_vi,
    input  logic [ADDR_W-1:0] vr_addr,
    input  logic [ADDR_W-1:0] vw_addr,
    input  logic [ADDR_W-1:0] itr_in,
    input  logic              wen_itr,
    output logic              stall,
    output logic [ADDR_W-1:0] rf_raddr,
    output logic              rf_ren,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic              rf_wen,
    output logic [2:0]        ctrl_din_sel,
    input  logic              ld_tvalid,
    output logic              ld_tready,
    output logic              st_tvalid,
    input  logic              st_tready,
    output logic              done
`ifdef VSEQ_PERF_CNT_EN
    ,
    output logic [31:0]       perf_busy_cycles,
    output logic [31:0]       perf_instr_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_VMV,
        OP_VMACC,
        OP_VLE,
        OP_VSE
    } op_t;

    state_t state;
    op_t    op;
    op_t    dec_op;

    logic [ADDR_W-1:0] itr;
    logic [ADDR_W-1:0] n;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] vr;
    logic [ADDR_W-1:0] vw;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;

    logic [MAC_LAT-1:0] mac_v;
    logic [ADDR_W-1:0]  mac_a [MAC_LAT];
    logic [MAC_LAT-1:0] tail_mask;

    logic accept;
    logic issuing;
    logic step;
    logic last;
    logic mac_rd;
    logic mac_wen;
    logic tail_empty;

    assign accept     = instr_valid & instr_ready;
    assign issuing    = (state == S_ISSUE);
    assign rd_addr    = vr + idx;
    assign wr_addr    = vw + idx;
    assign last       = step & (idx == n - ADDR_W'(1));
    assign mac_rd     = issuing & (op == OP_VMACC);
    assign mac_wen    = mac_v[MAC_LAT-1];
    assign tail_mask  = ~(MAC_LAT'(1) << (MAC_LAT - 1));
    assign tail_empty = ((mac_v & tail_mask) == '0);

    assign stall = (state != S_IDLE) |
                   (instr_valid & (is_vle32_vv | is_vse32_vv |
                                   is_vmacc_vv | is_vmv_vi));

    // Decode with fixed priority: vmacc > vle > vse > vmv.
    always_comb begin
        dec_op = OP_NOP;
        priority case (1'b1)
            is_vmacc_vv: dec_op = OP_VMACC;
            is_vle32_vv: dec_op = OP_VLE;
            is_vse32_vv: dec_op = OP_VSE;
            is_vmv_vi:   dec_op = OP_VMV;
            default:     dec_op = OP_NOP;
        endcase
    end

    // An element advances when its op-specific handshake is met.
    always_comb begin
        step = 1'b0;
        unique case (op)
            OP_VMV:   step = 1'b1;
            OP_VMACC: step = 1'b1;
            OP_VLE:   step = ld_tvalid;
            OP_VSE:   step = st_tready;
            default:  step = 1'b0;
        endcase
    end

    // RF and stream strobes; delayed MAC writebacks override.
    always_comb begin
        rf_ren       = 1'b0;
        rf_raddr     = '0;
        rf_wen       = 1'b0;
        rf_waddr     = '0;
        ctrl_din_sel = 3'b000;
        ld_tready    = 1'b0;
        if (issuing) begin
            unique case (op)
                OP_VMV: begin
                    rf_wen       = 1'b1;
                    rf_waddr     = wr_addr;
                    ctrl_din_sel = 3'b001;
                end
                OP_VMACC: begin
                    rf_ren   = 1'b1;
                    rf_raddr = rd_addr;
                end
                OP_VLE: begin
                    ld_tready = 1'b1;
                    if (ld_tvalid) begin
                        rf_wen       = 1'b1;
                        rf_waddr     = wr_addr;
                        ctrl_din_sel = 3'b100;
                    end
                end
                OP_VSE: begin
                    if (st_tready) begin
                        rf_ren   = 1'b1;
                        rf_raddr = rd_addr;
                    end
                end
                default: ;
            endcase
        end
        if (mac_wen) begin
            rf_wen       = 1'b1;
            rf_waddr     = mac_a[MAC_LAT-1];
            ctrl_din_sel = 3'b010;
        end
    end

    // Element-count register, writable at any time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            itr <= '0;
        end else if (wen_itr) begin
            itr <= itr_in;
        end
    end

    // Sequencer FSM with registered ready/done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            op          <= OP_NOP;
            n           <= '0;
            idx         <= '0;
            vr          <= '0;
            vw          <= '0;
            instr_ready <= 1'b1;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        op          <= dec_op;
                        n           <= itr;
                        vr          <= vr_addr;
                        vw          <= vw_addr;
                        idx         <= '0;
                        instr_ready <= 1'b0;
                        if (dec_op == OP_NOP || itr == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (step) begin
                        idx <= idx + ADDR_W'(1);
                        if (last) begin
                            if (op == OP_VMACC || op == OP_VSE) begin
                                state <= S_DRAIN;
                            end else begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (op == OP_VSE || tail_empty) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state       <= S_IDLE;
                    instr_ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // MAC writeback delay line: read slot -> write slot MAC_LAT later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mac_v <= '0;
            for (int i = 0; i < MAC_LAT; i++) begin
                mac_a[i] <= '0;
            end
        end else begin
            mac_v[0] <= mac_rd;
            mac_a[0] <= wr_addr;
            for (int i = 1; i < MAC_LAT; i++) begin
                mac_v[i] <= mac_v[i-1];
                mac_a[i] <= mac_a[i-1];
            end
        end
    end

    // Store beat valid follows the RF read by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_tvalid <= 1'b0;
        end else begin
            st_tvalid <= issuing & (op == OP_VSE) & st_tready;
        end
    end

`ifdef VSEQ_PERF_CNT_EN
    // Saturating busy-cycle and completed-instruction counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_busy_cycles <= '0;
            perf_instr_cnt   <= '0;
        end else begin
            if (state != S_IDLE && perf_busy_cycles != '1) begin
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            end
            if (done && perf_instr_cnt != '1) begin
                perf_instr_cnt <= perf_instr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vector_issue_sequencer.sv
// tb_vector_issue_sequencer: directed plus random instructions
// checked against an elapsed-cycle / element-count model.
module tb_vector_issue_sequencer;

    localparam int AW    = 10;
    localparam int LAT   = 4;
    localparam int M_NOP = 0;
    localparam int M_VMV = 1;
    localparam int M_MAC = 2;
    localparam int M_VLE = 3;
    localparam int M_VSE = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          instr_valid = 1'b0;
    logic          is_vle32_vv = 1'b0;
    logic          is_vse32_vv = 1'b0;
    logic          is_vmacc_vv = 1'b0;
    logic          is_vmv_vi = 1'b0;
    logic [AW-1:0] vr_addr = '0;
    logic [AW-1:0] vw_addr = '0;
    logic [AW-1:0] itr_in = '0;
    logic          wen_itr = 1'b0;
    logic          ld_tvalid = 1'b0;
    logic          st_tready = 1'b0;

    logic          instr_ready;
    logic          stall;
    logic [AW-1:0] rf_raddr;
    logic          rf_ren;
    logic [AW-1:0] rf_waddr;
    logic          rf_wen;
    logic [2:0]    ctrl_din_sel;
    logic          ld_tready;
    logic          st_tvalid;
    logic          done;
`ifdef VSEQ_PERF_CNT_EN
    logic [31:0]   perf_busy_cycles;
    logic [31:0]   perf_instr_cnt;
`endif

    int total = 0;
    int bad = 0;
    int m_itr = 0;
    int m_busy = 0;
    int m_done = 0;
    bit tv_q[$];
    bit tr_q[$];

    vector_issue_sequencer #(
        .ADDR_W (AW),
        .MAC_LAT(LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .is_vle32_vv (is_vle32_vv),
        .is_vse32_vv (is_vse32_vv),
        .is_vmacc_vv (is_vmacc_vv),
        .is_vmv_vi   (is_vmv_vi),
        .vr_addr     (vr_addr),
        .vw_addr     (vw_addr),
        .itr_in      (itr_in),
        .wen_itr     (wen_itr),
        .stall       (stall),
        .rf_raddr    (rf_raddr),
        .rf_ren      (rf_ren),
        .rf_waddr    (rf_waddr),
        .rf_wen      (rf_wen),
        .ctrl_din_sel(ctrl_din_sel),
        .ld_tvalid   (ld_tvalid),
        .ld_tready   (ld_tready),
        .st_tvalid   (st_tvalid),
        .st_tready   (st_tready),
        .done        (done)
`ifdef VSEQ_PERF_CNT_EN
        ,
        .perf_busy_cycles(perf_busy_cycles),
        .perf_instr_cnt  (perf_instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic set_flags(input logic [3:0] f);
        {is_vmacc_vv, is_vle32_vv, is_vse32_vv, is_vmv_vi} = f;
    endtask

    function automatic int dec(input logic [3:0] f);
        if (f[3]) return M_MAC;
        if (f[2]) return M_VLE;
        if (f[1]) return M_VSE;
        if (f[0]) return M_VMV;
        return M_NOP;
    endfunction

    task automatic chk_quiet(input string p);
        chk({p, "_ready"}, 32'(instr_ready), 32'd1);
        chk({p, "_wen"}, 32'(rf_wen), 32'd0);
        chk({p, "_ren"}, 32'(rf_ren), 32'd0);
        chk({p, "_sel"}, 32'(ctrl_din_sel), 32'd0);
        chk({p, "_ldr"}, 32'(ld_tready), 32'd0);
        chk({p, "_stv"}, 32'(st_tvalid), 32'd0);
        chk({p, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic idle_cycle(input bit wr, input int v);
        @(negedge clk);
        instr_valid = 1'b0;
        set_flags(4'b0000);
        wen_itr   = wr;
        itr_in    = AW'(v);
        ld_tvalid = 1'($urandom);
        st_tready = 1'($urandom);
        #1;
        chk_quiet("idle");
        chk("idle_stall", 32'(stall), 32'd0);
        @(posedge clk);
        if (wr) m_itr = v;
    endtask

    task automatic run_instr(input logic [3:0] f, input logic [AW-1:0] vr,
                             input logic [AW-1:0] vw, input int abort_at);
        int op, n, t, k, last_rd, e_sel, e_wa, e_ra;
        bit e_wen, e_ren, e_ldr, e_stv, e_done, prev_ren;
        op = dec(f);
        n  = m_itr;
        if (n == 0) op = M_NOP;
        @(negedge clk);
        instr_valid = 1'b1;
        set_flags(f);
        vr_addr   = vr;
        vw_addr   = vw;
        wen_itr   = 1'b0;
        ld_tvalid = 1'($urandom);
        st_tready = 1'($urandom);
        #1;
        chk_quiet("acc");
        chk("acc_stall", 32'(stall), 32'(f != 4'b0000));
        @(posedge clk);
        k = 0;
        t = 0;
        last_rd  = 0;
        prev_ren = 1'b0;
        e_done   = 1'b0;
        while (!e_done) begin
            t++;
            @(negedge clk);
            instr_valid = 1'($urandom);
            set_flags(4'($urandom));
            vr_addr   = AW'($urandom);
            vw_addr   = AW'($urandom);
            wen_itr   = ($urandom_range(0, 3) == 0);
            itr_in    = AW'($urandom_range(0, 9));
            ld_tvalid = (tv_q.size() > 0) ? tv_q.pop_front() : 1'($urandom);
            st_tready = (tr_q.size() > 0) ? tr_q.pop_front() : 1'($urandom);
            if (t == abort_at) begin
                instr_valid = 1'b0;
                set_flags(4'b0000);
                wen_itr = 1'b0;
                rst     = 1'b0;
                #1;
                chk_quiet("rst");
                chk("rst_stall", 32'(stall), 32'd0);
                m_itr  = 0;
                m_busy = 0;
                m_done = 0;
                repeat (2) begin
                    @(posedge clk);
                    #1;
                    chk("rst_hold_done", 32'(done), 32'd0);
                    chk("rst_hold_wen", 32'(rf_wen), 32'd0);
                end
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            #1;
            e_wen = 0; e_ren = 0; e_ldr = 0; e_stv = 0; e_done = 0;
            e_sel = 0; e_wa = 0; e_ra = 0;
            case (op)
                M_VMV: begin
                    if (t <= n) begin
                        e_wen = 1; e_sel = 1; e_wa = (vw + t - 1) % 1024;
                    end
                    e_done = (t == n + 1);
                end
                M_MAC: begin
                    if (t <= n) begin
                        e_ren = 1; e_ra = (vr + t - 1) % 1024;
                    end
                    if (t > LAT && t <= n + LAT) begin
                        e_wen = 1; e_sel = 2; e_wa = (vw + t - LAT - 1) % 1024;
                    end
                    e_done = (t == n + LAT + 1);
                end
                M_VLE: begin
                    e_ldr = (k < n);
                    if (k < n && ld_tvalid) begin
                        e_wen = 1; e_sel = 4; e_wa = (vw + k) % 1024;
                    end
                    e_done = (k == n);
                end
                M_VSE: begin
                    if (k < n && st_tready) begin
                        e_ren = 1; e_ra = (vr + k) % 1024;
                    end
                    e_stv  = prev_ren;
                    e_done = (k == n) && (t == last_rd + 2);
                end
                default: e_done = (t == 1);
            endcase
            chk("busy_ready", 32'(instr_ready), 32'd0);
            chk("busy_stall", 32'(stall), 32'd1);
            chk("wen", 32'(rf_wen), 32'(e_wen));
            chk("ren", 32'(rf_ren), 32'(e_ren));
            chk("sel", 32'(ctrl_din_sel), 32'(e_sel));
            chk("ld_tready", 32'(ld_tready), 32'(e_ldr));
            chk("st_tvalid", 32'(st_tvalid), 32'(e_stv));
            chk("done", 32'(done), 32'(e_done));
            if (e_wen) chk("waddr", 32'(rf_waddr), 32'(e_wa));
            if (e_ren) chk("raddr", 32'(rf_raddr), 32'(e_ra));
            @(posedge clk);
            if (wen_itr) m_itr = int'(itr_in);
            if (op == M_VLE && e_wen) k++;
            if (op == M_VSE && e_ren) begin
                k++;
                if (k == n) last_rd = t;
            end
            prev_ren = e_ren && (op == M_VSE);
            if (t > 600) begin
                chk("cycle_bound", 32'(t), 32'd600);
                e_done = 1'b1;
            end
        end
        m_busy += t;
        m_done++;
    endtask

    initial begin
        logic [3:0] f;
        int r;
        #1;
        rst = 1'b0;
        #2;
        chk_quiet("reset");
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_raddr", 32'(rf_raddr), 32'd0);
        chk("reset_waddr", 32'(rf_waddr), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        idle_cycle(1, 4);
        run_instr(4'b0001, AW'('h000), AW'('h100), 0);
        idle_cycle(1, 3);
        run_instr(4'b1000, AW'('h040), AW'('h080), 0);
        idle_cycle(1, 4);
        tv_q = '{1, 0, 1, 1, 1};
        run_instr(4'b0100, AW'('h000), AW'('h3FE), 0);
        idle_cycle(1, 2);
        tr_q = '{0, 0, 0, 1, 1};
        run_instr(4'b0010, AW'('h010), AW'('h000), 0);
        idle_cycle(1, 0);
        run_instr(4'b0001, AW'('h005), AW'('h006), 0);
        idle_cycle(0, 0);
        idle_cycle(1, 5);
        run_instr(4'b0000, AW'('h005), AW'('h006), 0);
        idle_cycle(0, 0);
        idle_cycle(1, 2);
        run_instr(4'b1111, AW'('h020), AW'('h030), 0);
        idle_cycle(1, 3);
        run_instr(4'b0110, AW'('h3FF), AW'('h3FD), 0);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 2);
            for (int j = 0; j < r; j++) begin
                idle_cycle(($urandom_range(0, 1) == 1), $urandom_range(0, 9));
            end
            r = $urandom_range(0, 9);
            f = (r < 8) ? 4'(1 << (r % 4)) : 4'($urandom_range(0, 15));
            run_instr(f, AW'($urandom), AW'($urandom), 0);
        end

        idle_cycle(1, 6);
        run_instr(4'b1000, AW'('h040), AW'('h080), 3);
        idle_cycle(0, 0);
        idle_cycle(0, 0);
        run_instr(4'b0001, AW'('h000), AW'('h200), 0);
        idle_cycle(1, 2);
        run_instr(4'b1000, AW'('h100), AW'('h3FF), 0);
        idle_cycle(0, 0);

`ifdef VSEQ_PERF_CNT_EN
        chk("perf_busy", perf_busy_cycles, 32'(m_busy));
        chk("perf_instr", perf_instr_cnt, 32'(m_done));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
